cnn_layer_sequencer: RTL and testbench
======================================

# cnn_layer_sequencer

Top-level scheduler for the CNN accelerator's chain of convolution and dense layer engines. It starts each engine in turn and holds its level-sensitive `start` high while the engine runs. It watches the engine's `done`, pulses a capture strobe so the layer's output register is latched, then moves to the next layer. A per-layer watchdog detects hangs, and a stale-`done` check covers the engines' lack of reset.

## Interface
- `NUM_LAYERS`, default 4: number of layer engines sequenced, in index order 0..NUM_LAYERS-1.
- `TIMEOUT`, default 1048576: maximum WAIT cycles per layer before a fault.
- `CW`, default $clog2(TIMEOUT+1): cycle-counter width.
- `clock` in 1: single clock. All logic is posedge.
- `reset` in 1: synchronous, active-high. It is sampled on the clock edge.
- `run` in 1: request to run the full layer chain. Sampled only in IDLE.
- `abort` in 1: synchronous abort. It wins over `run`.
- `layer_done` in NUM_LAYERS: engine done flags. Level signals, possibly stale-high.
- `layer_start` out NUM_LAYERS: engine start levels. At most one bit is high.
- `capture_en` out NUM_LAYERS: one-cycle strobe that latches layer i's output.
- `busy` out 1: high from accepted `run` until completion, abort or fault.
- `done` out 1: sticky completion flag. Cleared when the next `run` is accepted.
- `error` out 1: sticky fault flag. Cleared only by `reset`.
- `err_code` out 2: 0 none, 1 timeout, 2 stale done.
- `err_layer` out $clog2(NUM_LAYERS): layer index at which the fault occurred.
- `layer_cycles` out CW: WAIT-cycle count of the most recently completed layer.

## Operation
- States: IDLE, CHECK, WAIT, NEXT, FAULT. Layer index `idx` is held in a register; cycle counter `cyc` is CW bits wide.
- Reset values: state IDLE, idx 0, cyc 0, and every output 0.
- IDLE: if `run=1` and `abort=0` → idx=0, busy=1, done=0, next state CHECK.
- CHECK:
  - If `layer_done[idx]=1` → FAULT, err_code=2, err_layer=idx. The engine was not reset and its done is stale.
  - Otherwise → layer_start[idx]=1, cyc=0, next state WAIT.
- WAIT, with layer_start[idx] held high:
  - If `layer_done[idx]=1` → capture_en[idx]=1, layer_cycles=cyc, next state NEXT.
  - Else if cyc==TIMEOUT-1 → FAULT, err_code=1, err_layer=idx.
  - Else cyc+1.
  - If done and the timeout condition hit on the same edge, done wins.
- NEXT: capture_en=0 and layer_start[idx]=0.
  - If idx==NUM_LAYERS-1 → done=1, busy=0, next state IDLE.
  - Otherwise idx+1, next state CHECK.
- FAULT: all layer_start and capture_en are 0, busy=0, error=1. The state is left only by `reset`. `run` and `abort` are ignored.
- `layer_done` bits other than idx are ignored in every state. Earlier layers keep done high by design.
- `abort=1` in CHECK, WAIT or NEXT → next edge: state IDLE, all layer_start and capture_en 0, busy=0, done unchanged (0). An abort during NEXT suppresses the done/advance.
- `reset` mid-run → next edge returns all state and outputs to reset values. Engines are released by the drop of start.

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- `run` accepted at edge N → CHECK at N+1 → layer_start[0] high after edge N+1.
- If the engine asserts done before edge N+1+k, the WAIT edge samples it: capture_en is high for exactly one cycle and layer_cycles = k-1.
- Per-layer overhead is 2 cycles (CHECK, NEXT) plus WAIT cycles.
- The start of layer i+1 follows the capture_en of layer i by 2 edges.
- `done` rises on the NEXT edge of the last layer. It stays high until the next `run` is accepted.
- A timeout fault is flagged on the TIMEOUT-th WAIT edge without done.

## Structure
- Package `cnn_ctrl_pkg` holds:
  - the state enum (IDLE/CHECK/WAIT/NEXT/FAULT);
  - the err_code constants ERR_NONE, ERR_TIMEOUT, ERR_STALE;
  - the default TIMEOUT.
- One sub-module, `layer_watchdog`, implements the CW-bit counter. Inputs: clear and enable. Output: an `expired` flag at TIMEOUT-1.

## Test plan
- NUM_LAYERS=4, engines assert done after 10, 20, 5, 1 WAIT cycles → strictly one-hot layer_start; four capture_en pulses; layer_cycles 9, 19, 4, 0; done=1 and busy=0 two edges after the last done.
- layer_done[1] held high before `run` (stale) → FAULT after layer 0 completes, err_code=2, err_layer=1, layer_start[1] never asserted.
- TIMEOUT=16, layer 2 never finishes → error=1, err_code=1, err_layer=2 on the 16th WAIT edge; layer_start all 0; a later `run` is ignored.
- Layer 1 done arrives on the same edge as the timeout → capture_en[1] pulses, no fault, sequence continues.
- `abort` during WAIT of layer 2 → next edge all layer_start 0, busy=0, done=0; a new `run` restarts at layer 0.
- `reset` asserted in WAIT of layer 3 → all outputs 0 on the next edge; `run` with `run` and `abort` both high is not accepted.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// Shared types and constants for the CNN layer sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cnn_ctrl_pkg;

    // Sequencer states; FAULT is only left through reset.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_WAIT  = 3'd2,
        ST_NEXT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // err_code encodings
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_STALE   = 2'd2;

    // Default per-layer WAIT budget in cycles
    localparam int DEFAULT_TIMEOUT = 1048576;

endpackage

// File: rtl/layer_watchdog.sv
// Per-layer WAIT cycle counter with an expiry flag at TIMEOUT-1.
// Latency: count updates one cycle after clear/enable; expired is decoded from the count register.
// Backpressure: none; the sequencer decides when to count and when to clear.
//
// Ports:
//   i_clock, i_reset : clock and synchronous active-high reset
//   i_clear          : zero the count (takes priority over enable)
//   i_enable         : advance the count by one
//   o_count          : current count
//   o_expired        : count has reached TIMEOUT-1
module layer_watchdog
    import cnn_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [CW-1:0] o_count,
    output logic          o_expired
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count   = r_count;
    assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Starts each layer engine in turn, strobes capture on its done, and flags hangs or stale done levels.
// Latency: run->start 2 edges; done sampled->capture 1 edge; capture->next start 2 edges; all outputs registered.
// Backpressure: none; engines are held by a level start, abort/reset drop start to release them.
//
// Ports:
//   i_clock, i_reset  : clock and synchronous active-high reset
//   i_run, i_abort    : chain request (sampled in IDLE) and abort (wins over run)
//   i_layer_done      : per-engine done levels, possibly stale-high
//   o_layer_start     : per-engine start levels, at most one high
//   o_capture_en      : one-cycle strobe latching layer i's output
//   o_busy, o_done    : chain in progress / sticky completion
//   o_error, o_err_code, o_err_layer : sticky fault, its cause and layer
//   o_layer_cycles    : WAIT cycle count of the last completed layer
module cnn_layer_sequencer
    import cnn_ctrl_pkg::*;
#(
    parameter int  NUM_LAYERS = 4,
    parameter int  TIMEOUT    = DEFAULT_TIMEOUT,
    parameter int  CW         = $clog2(TIMEOUT + 1),
    localparam int IW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_run,
    input  logic                  i_abort,
    input  logic [NUM_LAYERS-1:0] i_layer_done,
    output logic [NUM_LAYERS-1:0] o_layer_start,
    output logic [NUM_LAYERS-1:0] o_capture_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [1:0]            o_err_code,
    output logic [IW-1:0]         o_err_layer,
    output logic [CW-1:0]         o_layer_cycles
);

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [NUM_LAYERS-1:0] r_layer_start;
    logic [NUM_LAYERS-1:0] r_capture_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [1:0]            r_err_code;
    logic [IW-1:0]         r_err_layer;
    logic [CW-1:0]         r_layer_cycles;

    state_t                w_state_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic [NUM_LAYERS-1:0] w_layer_start_nxt;
    logic [NUM_LAYERS-1:0] w_capture_en_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_error_nxt;
    logic [1:0]            w_err_code_nxt;
    logic [IW-1:0]         w_err_layer_nxt;
    logic [CW-1:0]         w_layer_cycles_nxt;

    logic                  w_wd_clear;
    logic                  w_wd_enable;
    logic [CW-1:0]         w_cyc;
    logic                  w_expired;

    // Only the current layer's done matters; earlier engines keep theirs high.
    logic                  w_cur_done;
    logic                  w_last;
    logic [NUM_LAYERS-1:0] w_sel;

    assign w_cur_done = i_layer_done[r_idx];
    assign w_last     = (r_idx == IW'(NUM_LAYERS - 1));
    assign w_sel      = NUM_LAYERS'(1) << r_idx;

    layer_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_watchdog (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (w_wd_clear),
        .i_enable  (w_wd_enable),
        .o_count   (w_cyc),
        .o_expired (w_expired)
    );

    // State and output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_layer_start  <= '0;
            r_capture_en   <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_err_code     <= ERR_NONE;
            r_err_layer    <= '0;
            r_layer_cycles <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_layer_start  <= w_layer_start_nxt;
            r_capture_en   <= w_capture_en_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_error        <= w_error_nxt;
            r_err_code     <= w_err_code_nxt;
            r_err_layer    <= w_err_layer_nxt;
            r_layer_cycles <= w_layer_cycles_nxt;
        end
    end

    // Next-state logic; abort outranks every other transition it can see.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_run && !i_abort) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (i_abort)         w_state_nxt = ST_IDLE;
                else if (w_cur_done) w_state_nxt = ST_FAULT;
                else                 w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // done beats a timeout landing on the same edge
                if (i_abort)         w_state_nxt = ST_IDLE;
                else if (w_cur_done) w_state_nxt = ST_NEXT;
                else if (w_expired)  w_state_nxt = ST_FAULT;
            end
            ST_NEXT: begin
                if (i_abort || w_last) w_state_nxt = ST_IDLE;
                else                   w_state_nxt = ST_CHECK;
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs and watchdog controls
    always_comb begin
        w_idx_nxt          = r_idx;
        w_layer_start_nxt  = r_layer_start;
        w_capture_en_nxt   = '0;
        w_busy_nxt         = r_busy;
        w_done_nxt         = r_done;
        w_error_nxt        = r_error;
        w_err_code_nxt     = r_err_code;
        w_err_layer_nxt    = r_err_layer;
        w_layer_cycles_nxt = r_layer_cycles;
        w_wd_clear         = 1'b0;
        w_wd_enable        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_run && !i_abort) begin
                    w_idx_nxt  = '0;
                    w_busy_nxt = 1'b1;
                    w_done_nxt = 1'b0;
                end
            end
            ST_CHECK: begin
                if (i_abort) begin
                    w_layer_start_nxt = '0;
                    w_busy_nxt        = 1'b0;
                end else if (w_cur_done) begin
                    // Engine has no reset: a done already high here is left over.
                    w_layer_start_nxt = '0;
                    w_busy_nxt        = 1'b0;
                    w_error_nxt       = 1'b1;
                    w_err_code_nxt    = ERR_STALE;
                    w_err_layer_nxt   = r_idx;
                end else begin
                    w_layer_start_nxt = w_sel;
                    w_wd_clear        = 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_abort) begin
                    w_layer_start_nxt = '0;
                    w_busy_nxt        = 1'b0;
                end else if (w_cur_done) begin
                    w_capture_en_nxt   = w_sel;
                    w_layer_cycles_nxt = w_cyc;
                end else if (w_expired) begin
                    w_layer_start_nxt = '0;
                    w_busy_nxt        = 1'b0;
                    w_error_nxt       = 1'b1;
                    w_err_code_nxt    = ERR_TIMEOUT;
                    w_err_layer_nxt   = r_idx;
                end else begin
                    w_wd_enable = 1'b1;
                end
            end
            ST_NEXT: begin
                w_layer_start_nxt = '0;
                if (i_abort) begin
                    w_busy_nxt = 1'b0;
                end else if (w_last) begin
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end else begin
                    w_idx_nxt = r_idx + IW'(1);
                end
            end
            default: begin
                w_layer_start_nxt = '0;
                w_busy_nxt        = 1'b0;
            end
        endcase
    end

    assign o_layer_start  = r_layer_start;
    assign o_capture_en   = r_capture_en;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_err_code     = r_err_code;
    assign o_err_layer    = r_err_layer;
    assign o_layer_cycles = r_layer_cycles;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: table of chain scenarios plus abort/reset sequences.
// Two instances: default TIMEOUT and TIMEOUT=16, sharing inputs, one selected at a time.
// A cycle model of the engines pushes expected captures; the capture monitor pops them.
module tb_cnn_layer_sequencer;
    import cnn_ctrl_pkg::*;

    localparam int NL   = 4;
    localparam int TO16 = 16;

    logic          clock = 1'b0;
    logic          reset, run, abort;
    logic [NL-1:0] layer_done;
    logic          sel;

    logic [NL-1:0] d_start, d_cap, s_start, s_cap;
    logic          d_busy, d_done, d_error, s_busy, s_done, s_error;
    logic [1:0]    d_code, d_layer, s_code, s_layer;
    logic [20:0]   d_cycles;
    logic [4:0]    s_cycles;

    logic [NL-1:0] m_start, m_cap;
    logic          m_busy, m_done, m_error;
    logic [1:0]    m_code, m_layer;
    logic [31:0]   m_cycles;

    always #5 clock = ~clock;

    cnn_layer_sequencer #(.NUM_LAYERS(NL)) u_dut (
        .i_clock(clock), .i_reset(reset), .i_run(run), .i_abort(abort),
        .i_layer_done(layer_done), .o_layer_start(d_start), .o_capture_en(d_cap),
        .o_busy(d_busy), .o_done(d_done), .o_error(d_error), .o_err_code(d_code),
        .o_err_layer(d_layer), .o_layer_cycles(d_cycles)
    );

    cnn_layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT(TO16)) u_dut16 (
        .i_clock(clock), .i_reset(reset), .i_run(run), .i_abort(abort),
        .i_layer_done(layer_done), .o_layer_start(s_start), .o_capture_en(s_cap),
        .o_busy(s_busy), .o_done(s_done), .o_error(s_error), .o_err_code(s_code),
        .o_err_layer(s_layer), .o_layer_cycles(s_cycles)
    );

    assign m_start  = sel ? s_start : d_start;
    assign m_cap    = sel ? s_cap   : d_cap;
    assign m_busy   = sel ? s_busy  : d_busy;
    assign m_done   = sel ? s_done  : d_done;
    assign m_error  = sel ? s_error : d_error;
    assign m_code   = sel ? s_code  : d_code;
    assign m_layer  = sel ? s_layer : d_layer;
    assign m_cycles = sel ? 32'(s_cycles) : 32'(d_cycles);

    typedef struct packed {
        logic               sel;       // 1: TIMEOUT=16 instance
        logic               rst;       // reset before the run
        logic [NL-1:0][7:0] lat;       // WAIT cycles until done, 0 = never
        logic [NL-1:0]      stale;     // done bits already high before run
        logic               exp_done;
        logic               exp_err;
        logic [1:0]         code;
        logic [1:0]         elayer;
        logic [NL-1:0]      smask;     // starts that must have been seen
        logic [2:0]         ncap;
    } row_t;

    typedef struct packed {
        logic [1:0]  layer;
        logic [31:0] cyc;
    } exp_t;

    exp_t          q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            step = 0;
    int            lat_m[NL];
    int            cnt[NL];
    int            start_step[NL];
    int            last_done_step[NL];
    int            done_step, err_step, ncap_seen;
    logic [NL-1:0] seen_start;
    logic [NL-1:0] prev_cap = '0;
    logic          prev_done = 1'b0;
    logic          prev_err = 1'b0;
    row_t          tab[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: sample outputs after the edge, score captures, then update the engine model.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        step++;
        check("start_onehot", 32'($countones(m_start) <= 1), 1);
        if (prev_cap != '0) check("cap_width", 32'(m_cap & prev_cap), 0);
        if (m_cap != '0) begin
            ncap_seen++;
            if (q.size() == 0) begin
                check("cap_unexpected", 32'(m_cap), 0);
            end else begin
                e = q.pop_front();
                check("cap_layer", 32'(m_cap), 32'(1) << e.layer);
                check("layer_cycles", m_cycles, e.cyc);
            end
        end
        if (m_done && !prev_done) done_step = step;
        if (m_error && !prev_err) err_step = step;
        prev_cap   = m_cap;
        prev_done  = m_done;
        prev_err   = m_error;
        seen_start = seen_start | m_start;
        for (int i = 0; i < NL; i++) begin
            if (m_start[i]) cnt[i]++;
            else cnt[i] = 0;
            if (cnt[i] == 1) start_step[i] = step;
            if (m_start[i] && lat_m[i] != 0 && cnt[i] == lat_m[i] && !layer_done[i]) begin
                layer_done[i] = 1'b1;
                e.layer = 2'(i);
                e.cyc   = 32'(lat_m[i] - 1);
                q.push_back(e);
                last_done_step[i] = step;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        abort = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_start"}, 32'(m_start), 0);
        check({tag, "_cap"}, 32'(m_cap), 0);
        check({tag, "_busy"}, 32'(m_busy), 0);
        check({tag, "_done"}, 32'(m_done), 0);
        check({tag, "_error"}, 32'(m_error), 0);
        check({tag, "_code"}, 32'(m_code), 0);
        check({tag, "_layer"}, 32'(m_layer), 0);
        check({tag, "_cycles"}, m_cycles, 0);
    endtask

    task automatic wait_end(input int budget);
        int k = 0;
        while (!(m_done || m_error) && k < budget) begin
            tick();
            k++;
        end
        if (!(m_done || m_error)) check("run_budget", 32'(m_done | m_error), 1);
    endtask

    task automatic wait_start(input int i, input int budget);
        int k = 0;
        while (!m_start[i] && k < budget) begin
            tick();
            k++;
        end
        if (!m_start[i]) check("start_budget", 32'(m_start[i]), 1);
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic run_row(input row_t r);
        sel        = r.sel;
        layer_done = '0;
        for (int i = 0; i < NL; i++) lat_m[i] = int'(r.lat[i]);
        if (r.rst) begin
            do_reset();
            check_zero("reset");
        end
        layer_done = r.stale;
        q.delete();
        seen_start = '0;
        ncap_seen  = 0;
        done_step  = -1;
        err_step   = -1;
        start_run();
        check("accept_busy", 32'(m_busy), 1);
        check("accept_done_clr", 32'(m_done), 0);
        check("accept_start", 32'(m_start), 0);
        wait_end(400);
        check("end_done", 32'(m_done), 32'(r.exp_done));
        check("end_error", 32'(m_error), 32'(r.exp_err));
        check("end_code", 32'(m_code), 32'(r.code));
        if (r.exp_err) check("end_err_layer", 32'(m_layer), 32'(r.elayer));
        check("end_busy", 32'(m_busy), 0);
        check("starts_seen", 32'(seen_start), 32'(r.smask));
        check("capture_count", 32'(ncap_seen), 32'(r.ncap));
        check("queue_left", 32'(q.size()), 0);
        if (r.exp_done) check("done_latency", 32'(done_step - last_done_step[NL-1]), 2);
        if (r.code == ERR_TIMEOUT) check("timeout_latency", 32'(err_step - start_step[r.elayer]), TO16);
        if (r.exp_err) begin
            // FAULT must ignore a later run
            start_run();
            tick();
            check("fault_run_busy", 32'(m_busy), 0);
            check("fault_run_start", 32'(m_start), 0);
            check("fault_sticky", 32'(m_error), 1);
            check("fault_code_held", 32'(m_code), 32'(r.code));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b0; run = 1'b0; abort = 1'b0; layer_done = '0; sel = 1'b0;
        for (int i = 0; i < NL; i++) begin
            cnt[i] = 0; lat_m[i] = 0; start_step[i] = 0; last_done_step[i] = 0;
        end
        seen_start = '0;
        ncap_seen  = 0;

        // lat is listed layer 3 first
        tab[0] = '{sel:1'b0, rst:1'b1, lat:{8'd1, 8'd5, 8'd20, 8'd10}, stale:4'b0000,
                   exp_done:1'b1, exp_err:1'b0, code:ERR_NONE, elayer:2'd0, smask:4'b1111, ncap:3'd4};
        tab[1] = '{sel:1'b0, rst:1'b0, lat:{8'd1, 8'd1, 8'd1, 8'd1}, stale:4'b0000,
                   exp_done:1'b1, exp_err:1'b0, code:ERR_NONE, elayer:2'd0, smask:4'b1111, ncap:3'd4};
        tab[2] = '{sel:1'b0, rst:1'b0, lat:{8'd2, 8'd2, 8'd2, 8'd3}, stale:4'b0010,
                   exp_done:1'b0, exp_err:1'b1, code:ERR_STALE, elayer:2'd1, smask:4'b0001, ncap:3'd1};
        tab[3] = '{sel:1'b1, rst:1'b1, lat:{8'd1, 8'd1, 8'd16, 8'd2}, stale:4'b0000,
                   exp_done:1'b1, exp_err:1'b0, code:ERR_NONE, elayer:2'd0, smask:4'b1111, ncap:3'd4};
        tab[4] = '{sel:1'b1, rst:1'b0, lat:{8'd16, 8'd16, 8'd16, 8'd16}, stale:4'b0000,
                   exp_done:1'b1, exp_err:1'b0, code:ERR_NONE, elayer:2'd0, smask:4'b1111, ncap:3'd4};
        tab[5] = '{sel:1'b1, rst:1'b0, lat:{8'd3, 8'd0, 8'd6, 8'd4}, stale:4'b0000,
                   exp_done:1'b0, exp_err:1'b1, code:ERR_TIMEOUT, elayer:2'd2, smask:4'b0111, ncap:3'd2};

        for (int r = 0; r < 6; r++) run_row(tab[r]);

        // Abort in WAIT of layer 2, then a clean restart from layer 0
        sel = 1'b0;
        lat_m = '{2, 2, 0, 1};
        do_reset();
        layer_done = '0;
        q.delete();
        start_run();
        wait_start(2, 100);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_start", 32'(m_start), 0);
        check("abort_busy", 32'(m_busy), 0);
        check("abort_done", 32'(m_done), 0);
        check("abort_error", 32'(m_error), 0);
        layer_done = '0;
        lat_m = '{1, 1, 1, 1};
        start_run();
        check("restart_busy", 32'(m_busy), 1);
        tick();
        check("restart_layer0", 32'(m_start), 32'b0001);
        wait_end(100);
        check("restart_done", 32'(m_done), 1);
        check("restart_queue", 32'(q.size()), 0);

        // Reset in WAIT of layer 3, then run with abort high must not be taken
        lat_m = '{2, 3, 4, 0};
        do_reset();
        layer_done = '0;
        q.delete();
        start_run();
        wait_start(3, 100);
        tick();
        tick();
        check("pre_reset_cycles", m_cycles, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_zero("midrun_reset");
        layer_done = '0;
        run   = 1'b1;
        abort = 1'b1;
        tick();
        run   = 1'b0;
        abort = 1'b0;
        check("run_abort_busy", 32'(m_busy), 0);
        tick();
        check("run_abort_start", 32'(m_start), 0);
        check("run_abort_busy2", 32'(m_busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
